// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: bus word type and grant state encoding.
package mem_arbiter_pkg;

    typedef logic [31:0] size_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    // Instruction fetches are always full-word reads.
    localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mem_arbiter_stall_watchdog.sv
// Stuck-slave watchdog: counts consecutive stalled grant cycles and raises a
// sticky bus_timeout when the count reaches TIMEOUT_CYCLES.
module mem_arbiter_stall_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned CNT_W          = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic stall_en,
    output logic bus_timeout
);

    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt   <= '0;
            bus_timeout <= 1'b0;
        end else begin
            if (clear) begin
                stall_cnt <= '0;
            end else if (stall_en && (stall_cnt != LIMIT)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            // The flag is set on the stall cycle that brings the count to LIMIT.
            if (!clear && stall_en && (stall_cnt == LIMIT_LAST)) begin
                bus_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester Avalon-MM arbiter (instruction fetch vs. data load/store).
// Build option MEM_ARB_ROUND_ROBIN_EN swaps fixed data priority for round-robin in IDLE.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned CNT_W          = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_read,
    input  size_t      i_address,
    output size_t      i_readdata,
    output logic       i_waitrequest,
    input  logic       d_read,
    input  logic       d_write,
    input  logic [3:0] d_byteenable,
    input  size_t      d_address,
    input  size_t      d_writedata,
    output size_t      d_readdata,
    output logic       d_waitrequest,
    output logic       m_read,
    output logic       m_write,
    output logic [3:0] m_byteenable,
    output size_t      m_address,
    output size_t      m_writedata,
    input  size_t      m_readdata,
    input  logic       m_waitrequest,
    output logic       grant_data,
    output logic       bus_timeout,
    output arb_state_t arb_state
);

    // Handshake: a granted access completes on the cycle its request is high
    // and m_waitrequest is low; the non-owner always sees waitrequest high.
    arb_state_t state, state_nxt;
    logic       req_d, req_i, prefer_d;

    assign req_d = d_read | d_write;
    assign req_i = i_read;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_d <= 1'b0;
        end else if (state == ARB_IDLE && state_nxt == ARB_GRANT_D) begin
            last_grant_d <= 1'b1;
        end else if (state == ARB_IDLE && state_nxt == ARB_GRANT_I) begin
            last_grant_d <= 1'b0;
        end
    end

    assign prefer_d = ~last_grant_d;
`else
    assign prefer_d = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_byteenable  = '0;
        m_address     = '0;
        m_writedata   = '0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;
        case (state)
            ARB_IDLE: begin
                if (req_d && (prefer_d || !req_i)) begin
                    state_nxt = ARB_GRANT_D;
                end else if (req_i) begin
                    state_nxt = ARB_GRANT_I;
                end
            end
            ARB_GRANT_I: begin
                m_read        = i_read;
                m_byteenable  = i_read ? BE_ALL : 4'h0;
                m_address     = i_address;
                i_waitrequest = m_waitrequest;
                if (!i_read) begin
                    state_nxt = ARB_IDLE;
                end else if (!m_waitrequest) begin
                    state_nxt = req_d ? ARB_GRANT_D : ARB_IDLE;
                end
            end
            ARB_GRANT_D: begin
                // Simultaneous read and write is a requester error; the write wins.
                m_write       = d_write;
                m_read        = d_read & ~d_write;
                m_byteenable  = d_byteenable;
                m_address     = d_address;
                m_writedata   = d_writedata;
                d_waitrequest = m_waitrequest;
                if (!req_d) begin
                    state_nxt = ARB_IDLE;
                end else if (!m_waitrequest) begin
                    state_nxt = req_i ? ARB_GRANT_I : ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign i_readdata = m_readdata;
    assign d_readdata = m_readdata;
    assign grant_data = (state == ARB_GRANT_D);
    assign arb_state  = state;

    mem_arbiter_stall_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_watchdog (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      ((state != state_nxt) | ~m_waitrequest),
        .stall_en   ((state != ARB_IDLE) & m_waitrequest),
        .bus_timeout(bus_timeout)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural Avalon-MM memory model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic       clk, reset_n;
    logic       i_read, i_waitrequest;
    size_t      i_address, i_readdata;
    logic       d_read, d_write, d_waitrequest;
    logic [3:0] d_byteenable, m_byteenable;
    size_t      d_address, d_writedata, d_readdata;
    logic       m_read, m_write, m_waitrequest;
    size_t      m_address, m_writedata, m_readdata;
    logic       grant_data, bus_timeout;
    arb_state_t arb_state;

    int n_cmp = 0;
    int n_err = 0;

    // Memory model controls
    int    wait_cfg = 0;
    logic  stuck    = 1'b0;
    int    stall_cnt;
    size_t mem [0:255];
    logic  written [0:255];
    size_t cur_word, merged;
    logic [7:0] idx;

    mem_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata),
        .i_waitrequest(i_waitrequest),
        .d_read(d_read), .d_write(d_write), .d_byteenable(d_byteenable),
        .d_address(d_address), .d_writedata(d_writedata), .d_readdata(d_readdata),
        .d_waitrequest(d_waitrequest),
        .m_read(m_read), .m_write(m_write), .m_byteenable(m_byteenable),
        .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
        .m_waitrequest(m_waitrequest),
        .grant_data(grant_data), .bus_timeout(bus_timeout), .arb_state(arb_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: unwritten words read back as ~address
    always_comb begin
        idx      = m_address[9:2];
        cur_word = written[idx] ? mem[idx] : ~m_address;
        for (int b = 0; b < 4; b++) begin
            merged[b*8 +: 8] = m_byteenable[b] ? m_writedata[b*8 +: 8] : cur_word[b*8 +: 8];
        end
        m_readdata    = cur_word;
        m_waitrequest = stuck | ((m_read | m_write) && (stall_cnt < wait_cfg));
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 0;
            for (int k = 0; k < 256; k++) written[k] <= 1'b0;
        end else begin
            if (!(m_read | m_write) || !m_waitrequest) stall_cnt <= 0;
            else stall_cnt <= stall_cnt + 1;
            if (m_write && !m_waitrequest) begin
                mem[idx]     <= merged;
                written[idx] <= 1'b1;
            end
        end
    end

    // Driver: one data access, bounded at 20 cycles; request dropped after completion
    task automatic d_access(input logic rd, input logic wr, input size_t addr, input size_t wdata,
                            input logic [3:0] be, output size_t rdata, output logic [3:0] be_seen,
                            output logic done);
        done = 1'b0; rdata = '0; be_seen = '0;
        @(negedge clk);
        d_read = rd; d_write = wr; d_address = addr; d_writedata = wdata; d_byteenable = be;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk); #1;
            if (!d_waitrequest) begin
                done = 1'b1; rdata = d_readdata; be_seen = m_byteenable;
            end
        end
        @(negedge clk);
        d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; i_read = 1'b1; i_address = 32'hBFC00000;
        d_read = 1'b0; d_write = 1'b0; d_byteenable = 4'h0; d_address = '0; d_writedata = '0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (arb_state !== ARB_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", arb_state, ARB_IDLE); end
        n_cmp++; if ({m_read, m_write, m_byteenable} !== 6'b0) begin n_err++; $display("FAIL rst_m_cmd: got %b want 0", {m_read, m_write, m_byteenable}); end
        n_cmp++; if ({m_address, m_writedata} !== 64'h0) begin n_err++; $display("FAIL rst_m_bus: got %h want 0", {m_address, m_writedata}); end
        n_cmp++; if ({i_waitrequest, d_waitrequest} !== 2'b11) begin n_err++; $display("FAIL rst_wait: got %b want 11", {i_waitrequest, d_waitrequest}); end
        n_cmp++; if ({grant_data, bus_timeout} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b want 00", {grant_data, bus_timeout}); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_cmp++; if (m_read !== 1'b0) begin n_err++; $display("FAIL fetch_latency: got m_read %b want 0", m_read); end
        @(negedge clk); #1;
        n_cmp++; if (arb_state !== ARB_GRANT_I) begin n_err++; $display("FAIL fetch_state: got %0d want %0d", arb_state, ARB_GRANT_I); end
        n_cmp++; if (m_read !== 1'b1 || m_address !== 32'hBFC00000) begin n_err++; $display("FAIL fetch_cmd: got rd %b addr %h want 1 BFC00000", m_read, m_address); end
        n_cmp++; if (i_waitrequest !== 1'b0) begin n_err++; $display("FAIL fetch_wait: got %b want 0", i_waitrequest); end
        n_cmp++; if (i_readdata !== 32'h403FFFFF) begin n_err++; $display("FAIL fetch_data: got %h want 403FFFFF", i_readdata); end
        @(negedge clk);
        i_read = 1'b0;
        #1;
        n_cmp++; if (arb_state !== ARB_IDLE) begin n_err++; $display("FAIL fetch_done: got %0d want %0d", arb_state, ARB_IDLE); end
    endtask

    task automatic test_back_to_back;
        size_t rd; logic [3:0] bes; logic ok;
        @(negedge clk);
        d_write = 1'b1; d_address = 32'hBFC00010; d_writedata = 32'hDEADBEEF; d_byteenable = 4'hF;
        i_read = 1'b1; i_address = 32'hBFC00000;
        #1;
        n_cmp++; if (m_write !== 1'b0) begin n_err++; $display("FAIL b2b_arb_latency: got m_write %b want 0", m_write); end
        @(negedge clk); #1;
        n_cmp++; if (arb_state !== ARB_GRANT_D || grant_data !== 1'b1) begin n_err++; $display("FAIL b2b_d_first: got state %0d gd %b want %0d 1", arb_state, grant_data, ARB_GRANT_D); end
        n_cmp++; if (m_write !== 1'b1 || m_read !== 1'b0 || m_address !== 32'hBFC00010 || m_writedata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL b2b_d_cmd: got wr %b rd %b addr %h data %h want 1 0 BFC00010 DEADBEEF", m_write, m_read, m_address, m_writedata); end
        n_cmp++; if ({d_waitrequest, i_waitrequest} !== 2'b01) begin n_err++; $display("FAIL b2b_d_wait: got %b want 01", {d_waitrequest, i_waitrequest}); end
        @(negedge clk);
        d_write = 1'b0;
        #1;
        n_cmp++; if (arb_state !== ARB_GRANT_I) begin n_err++; $display("FAIL b2b_no_bubble: got %0d want %0d", arb_state, ARB_GRANT_I); end
        n_cmp++; if (m_read !== 1'b1 || m_address !== 32'hBFC00000 || i_waitrequest !== 1'b0) begin
            n_err++; $display("FAIL b2b_i_cmd: got rd %b addr %h iw %b want 1 BFC00000 0", m_read, m_address, i_waitrequest); end
        @(negedge clk);
        i_read = 1'b0;
        d_access(1'b1, 1'b0, 32'hBFC00010, '0, 4'hF, rd, bes, ok);
        n_cmp++; if (ok !== 1'b1 || rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL b2b_readback: got ok %b data %h want 1 DEADBEEF", ok, rd); end
    endtask

    task automatic test_wait_states;
        @(negedge clk);
        wait_cfg = 3;
        d_read = 1'b1; d_address = 32'hBFC00010;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            n_cmp++; if ({d_waitrequest, i_waitrequest} !== 2'b11) begin n_err++; $display("FAIL ws_stall_%0d: got %b want 11", k, {d_waitrequest, i_waitrequest}); end
        end
        @(negedge clk); #1;
        n_cmp++; if (d_waitrequest !== 1'b0 || i_waitrequest !== 1'b1) begin n_err++; $display("FAIL ws_complete: got dw %b iw %b want 0 1", d_waitrequest, i_waitrequest); end
        n_cmp++; if (d_readdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL ws_data: got %h want DEADBEEF", d_readdata); end
        n_cmp++; if (bus_timeout !== 1'b0) begin n_err++; $display("FAIL ws_no_timeout: got %b want 0", bus_timeout); end
        @(negedge clk);
        d_read = 1'b0; wait_cfg = 0;
    endtask

    task automatic test_abort;
        @(negedge clk);
        stuck = 1'b1; d_read = 1'b1; d_address = 32'hBFC00040;
        @(negedge clk); #1;
        n_cmp++; if (arb_state !== ARB_GRANT_D || d_waitrequest !== 1'b1) begin n_err++; $display("FAIL abort_grant: got %0d dw %b want %0d 1", arb_state, d_waitrequest, ARB_GRANT_D); end
        @(negedge clk);
        d_read = 1'b0;
        #1;
        n_cmp++; if (m_read !== 1'b0) begin n_err++; $display("FAIL abort_cmd: got m_read %b want 0", m_read); end
        @(negedge clk); #1;
        n_cmp++; if (arb_state !== ARB_IDLE) begin n_err++; $display("FAIL abort_idle: got %0d want %0d", arb_state, ARB_IDLE); end
    endtask

    task automatic test_timeout;
        @(negedge clk);
        stuck = 1'b1; d_read = 1'b1; d_address = 32'hBFC00000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); #1;
            n_cmp++; if (bus_timeout !== 1'b0) begin n_err++; $display("FAIL to_early_%0d: got %b want 0", k, bus_timeout); end
        end
        @(negedge clk); #1;
        n_cmp++; if (bus_timeout !== 1'b1) begin n_err++; $display("FAIL to_set: got %b want 1", bus_timeout); end
        @(negedge clk);
        stuck = 1'b0;
        @(negedge clk);
        d_read = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (bus_timeout !== 1'b1 || arb_state !== ARB_IDLE) begin n_err++; $display("FAIL to_sticky: got to %b state %0d want 1 %0d", bus_timeout, arb_state, ARB_IDLE); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        stuck = 1'b1; d_write = 1'b1; d_address = 32'hBFC00030; d_writedata = 32'h55AA55AA; d_byteenable = 4'hF;
        @(negedge clk); #1;
        n_cmp++; if (m_write !== 1'b1 || d_waitrequest !== 1'b1) begin n_err++; $display("FAIL rm_stalled: got wr %b dw %b want 1 1", m_write, d_waitrequest); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({m_write, m_read, d_waitrequest, i_waitrequest} !== 4'b0011) begin
            n_err++; $display("FAIL rm_async: got wr,rd,dw,iw %b want 0011", {m_write, m_read, d_waitrequest, i_waitrequest}); end
        n_cmp++; if (arb_state !== ARB_IDLE || bus_timeout !== 1'b0) begin n_err++; $display("FAIL rm_state: got %0d to %b want %0d 0", arb_state, bus_timeout, ARB_IDLE); end
        d_write = 1'b0; stuck = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (arb_state !== ARB_IDLE || m_write !== 1'b0) begin n_err++; $display("FAIL rm_release: got %0d wr %b want %0d 0", arb_state, m_write, ARB_IDLE); end
    endtask

    task automatic test_byte_store;
        size_t rd; logic [3:0] bes; logic ok;
        d_access(1'b0, 1'b1, 32'hBFC00020, 32'h11223344, 4'hF, rd, bes, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL bs_full_write: got done %b want 1", ok); end
        d_access(1'b0, 1'b1, 32'hBFC00020, 32'h0000AB00, 4'b0010, rd, bes, ok);
        n_cmp++; if (ok !== 1'b1 || bes !== 4'b0010) begin n_err++; $display("FAIL bs_be: got done %b be %b want 1 0010", ok, bes); end
        d_access(1'b1, 1'b0, 32'hBFC00020, '0, 4'hF, rd, bes, ok);
        n_cmp++; if (ok !== 1'b1 || rd !== 32'h1122AB44) begin n_err++; $display("FAIL bs_readback: got done %b data %h want 1 1122AB44", ok, rd); end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_wait_states;
        test_abort;
        test_timeout;
        test_reset_mid;
        test_byte_store;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish want finish before 200000");
        $fatal(1, "simulation time limit");
    end

endmodule
